// File: rtl/issue_controller.sv
// Dual-slot in-order issue controller: decodes the two queue head slots, checks
// reservation-station room, pops 0/1/2 entries and tracks ADD/MUL RS occupancy.
module issue_controller #(
    parameter int unsigned ADD_RS_DEPTH = 3,
    parameter int unsigned MUL_RS_DEPTH = 2,
    parameter int unsigned CNT_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             inst1_valid,
    input  logic [7:0]       inst1_type,
    input  logic             inst2_valid,
    input  logic [7:0]       inst2_type,
    input  logic             add_done,
    input  logic             mul_done,
    output logic [1:0]       select_instruction,
    output logic             issue1_valid,
    output logic             issue1_rs,
    output logic             issue2_valid,
    output logic             issue2_rs,
    output logic [CNT_W-1:0] add_rs_used,
    output logic [CNT_W-1:0] mul_rs_used,
    output logic [15:0]      stall_cycles,
    output logic             halted
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W:0] ADD_LIM = (CNT_W+1)'(ADD_RS_DEPTH);
    localparam logic [CNT_W:0] MUL_LIM = (CNT_W+1)'(MUL_RS_DEPTH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] add_used_q, add_used_d;
    logic [CNT_W-1:0] mul_used_q, mul_used_d;
    logic [15:0]      stall_q, stall_d;
    logic             halted_q, halted_d;

    logic             is_add1_s, is_mul1_s, is_halt1_s;
    logic             is_add2_s, is_mul2_s, is_halt2_s;
    logic             room1_s, room2_s, iss1_s, iss2_s;
    logic [CNT_W-1:0] add_inc_s, mul_inc_s, add_dec_s, mul_dec_s;
    logic [CNT_W:0]   add_need2_s, mul_need2_s;

    // Decode, capacity check (registered counts only) and issue selection
    always_comb begin
        is_add1_s  = (inst1_type == 8'h01) || (inst1_type == 8'h02);
        is_mul1_s  = (inst1_type == 8'h03) || (inst1_type == 8'h04);
        is_halt1_s = (inst1_type == 8'hFF);
        is_add2_s  = (inst2_type == 8'h01) || (inst2_type == 8'h02);
        is_mul2_s  = (inst2_type == 8'h03) || (inst2_type == 8'h04);
        is_halt2_s = (inst2_type == 8'hFF);

        // Slot 2 must fit behind whatever slot 1 takes from the same station
        add_need2_s = {1'b0, add_used_q} + (CNT_W+1)'(is_add1_s) + {{CNT_W{1'b0}}, 1'b1};
        mul_need2_s = {1'b0, mul_used_q} + (CNT_W+1)'(is_mul1_s) + {{CNT_W{1'b0}}, 1'b1};

        if (is_add1_s) begin
            room1_s = ({1'b0, add_used_q} < ADD_LIM);
        end else if (is_mul1_s) begin
            room1_s = ({1'b0, mul_used_q} < MUL_LIM);
        end else begin
            room1_s = 1'b1;
        end

        if (is_add2_s) begin
            room2_s = (add_need2_s <= ADD_LIM);
        end else if (is_mul2_s) begin
            room2_s = (mul_need2_s <= MUL_LIM);
        end else begin
            room2_s = 1'b1;
        end

        iss1_s = (state_q == S_RUN) && inst1_valid && !is_halt1_s && room1_s;
        iss2_s = iss1_s && inst2_valid && !is_halt2_s && room2_s;

        if (iss2_s) begin
            select_instruction = 2'b10;
        end else if (iss1_s) begin
            select_instruction = 2'b01;
        end else begin
            select_instruction = 2'b00;
        end

        issue1_valid = iss1_s;
        issue1_rs    = iss1_s && is_mul1_s;
        issue2_valid = iss2_s;
        issue2_rs    = iss2_s && is_mul2_s;
    end

    // Next-state, occupancy, stall counter and halted flag
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
                else       state_d = S_IDLE;
            end
            S_RUN: begin
                if (inst1_valid && is_halt1_s) state_d = S_DRAIN;
                else                           state_d = S_RUN;
            end
            S_DRAIN: begin
                if ((add_used_q == {CNT_W{1'b0}}) && (mul_used_q == {CNT_W{1'b0}})) state_d = S_DONE;
                else                                                                state_d = S_DRAIN;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        add_inc_s  = CNT_W'(iss1_s && is_add1_s) + CNT_W'(iss2_s && is_add2_s);
        mul_inc_s  = CNT_W'(iss1_s && is_mul1_s) + CNT_W'(iss2_s && is_mul2_s);
        add_dec_s  = CNT_W'(add_done && (add_used_q != {CNT_W{1'b0}}));
        mul_dec_s  = CNT_W'(mul_done && (mul_used_q != {CNT_W{1'b0}}));
        add_used_d = add_used_q + add_inc_s - add_dec_s;
        mul_used_d = mul_used_q + mul_inc_s - mul_dec_s;

        if ((state_q == S_RUN) && (select_instruction == 2'b00) && inst1_valid && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end

        halted_d = (state_d == S_DONE);
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            add_used_q <= {CNT_W{1'b0}};
            mul_used_q <= {CNT_W{1'b0}};
            stall_q    <= 16'd0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            add_used_q <= add_used_d;
            mul_used_q <= mul_used_d;
            stall_q    <= stall_d;
            halted_q   <= halted_d;
        end
    end

    assign add_rs_used  = add_used_q;
    assign mul_rs_used  = mul_used_q;
    assign stall_cycles = stall_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_issue_controller.sv
// Directed bench for issue_controller: hand-computed vectors checked with immediate assertions.
module tb_issue_controller;

    logic        clk = 1'b0;
    logic        rst, start, inst1_valid, inst2_valid, add_done, mul_done;
    logic [7:0]  inst1_type, inst2_type;
    logic [1:0]  select_instruction;
    logic        issue1_valid, issue1_rs, issue2_valid, issue2_rs, halted;
    logic [2:0]  add_rs_used, mul_rs_used;
    logic [15:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    issue_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .inst1_valid(inst1_valid), .inst1_type(inst1_type),
        .inst2_valid(inst2_valid), .inst2_type(inst2_type),
        .add_done(add_done), .mul_done(mul_done),
        .select_instruction(select_instruction),
        .issue1_valid(issue1_valid), .issue1_rs(issue1_rs),
        .issue2_valid(issue2_valid), .issue2_rs(issue2_rs),
        .add_rs_used(add_rs_used), .mul_rs_used(mul_rs_used),
        .stall_cycles(stall_cycles), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and checks happen just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v1, input logic [7:0] t1, input logic v2, input logic [7:0] t2);
        inst1_valid = v1; inst1_type = t1;
        inst2_valid = v2; inst2_type = t2;
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic [1:0] sel,
                             input logic i1, input logic r1, input logic i2, input logic r2);
        chk({tag, "_sel"}, {14'd0, select_instruction}, {14'd0, sel});
        chk({tag, "_iss"}, {12'd0, issue1_valid, issue1_rs, issue2_valid, issue2_rs},
                           {12'd0, i1, r1, i2, r2});
    endtask

    task automatic chk_cnt(input string tag, input logic [2:0] a, input logic [2:0] m);
        chk({tag, "_add"}, {13'd0, add_rs_used}, {13'd0, a});
        chk({tag, "_mul"}, {13'd0, mul_rs_used}, {13'd0, m});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; add_done = 1'b0; mul_done = 1'b0;
        inst1_valid = 1'b0; inst1_type = 8'h00; inst2_valid = 1'b0; inst2_type = 8'h00;
        #12;
        chk_issue("rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("rst", 3'd0, 3'd0);
        chk("rst_stall", stall_cycles, 16'd0);
        chk("rst_halt", {15'd0, halted}, 16'd0);
        rst = 1'b0;

        // idle: valid instructions without start do not issue
        set_in(1'b1, 8'h01, 1'b1, 8'h03);
        chk_issue("idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;

        // ADD + MUL dual issue
        set_in(1'b1, 8'h01, 1'b1, 8'h03);
        chk_issue("t1", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        chk_cnt("t1", 3'd1, 3'd1);

        // MUL + DIV with mul=1: only one fits
        set_in(1'b1, 8'h03, 1'b1, 8'h04);
        chk_issue("t2a", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_cnt("t2a", 3'd1, 3'd2);
        chk_issue("t2b", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2b_stall0", stall_cycles, 16'd0);
        step();
        chk("t2b_stall1", stall_cycles, 16'd1);
        chk_cnt("t2b", 3'd1, 3'd2);

        // full MUL RS with same-cycle mul_done: no bypass
        mul_done = 1'b1;
        set_in(1'b1, 8'h03, 1'b0, 8'h00);
        chk_issue("t3a", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        mul_done = 1'b0;
        #1;
        chk_cnt("t3a", 3'd1, 3'd1);
        chk("t3a_stall", stall_cycles, 16'd2);
        chk_issue("t3b", 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_cnt("t3b", 3'd1, 3'd2);

        // NOP + SUB: both issue, only ADD RS grows
        set_in(1'b1, 8'h00, 1'b1, 8'h02);
        chk_issue("t5", 2'b10, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        chk_cnt("t5", 3'd2, 3'd2);

        // ADD RS boundary: 2 used, depth 3 -> only one of ADD,SUB
        set_in(1'b1, 8'h01, 1'b1, 8'h02);
        chk_issue("addb", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_cnt("addb", 3'd3, 3'd2);
        chk_issue("addfull", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("addfull_stall", stall_cycles, 16'd3);

        // simultaneous done on both stations, nothing valid
        set_in(1'b0, 8'h01, 1'b0, 8'h00);
        add_done = 1'b1; mul_done = 1'b1;
        step();
        add_done = 1'b0; mul_done = 1'b0;
        chk_cnt("done2", 3'd2, 3'd1);
        chk("done2_stall", stall_cycles, 16'd3);

        // HALT in slot 2: only inst1 issues
        set_in(1'b1, 8'h01, 1'b1, 8'hFF);
        chk_issue("t4a", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_cnt("t4a", 3'd3, 3'd1);
        // HALT at head: hold, go to DRAIN
        set_in(1'b1, 8'hFF, 1'b0, 8'h00);
        chk_issue("t4b", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 8'h01, 1'b1, 8'h03);
        chk_issue("drain", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drain_stall", stall_cycles, 16'd4);
        chk("drain_halt", {15'd0, halted}, 16'd0);
        add_done = 1'b1; mul_done = 1'b1;
        step();
        mul_done = 1'b0;
        chk_cnt("dr1", 3'd2, 3'd0);
        step();
        step();
        add_done = 1'b0;
        chk_cnt("dr3", 3'd0, 3'd0);
        chk("dr3_halt", {15'd0, halted}, 16'd0);
        step();
        chk("done_halt", {15'd0, halted}, 16'd1);
        // done at empty station does not underflow; start ignored in DONE
        add_done = 1'b1; start = 1'b1;
        step();
        add_done = 1'b0; start = 1'b0;
        chk_cnt("uflow", 3'd0, 3'd0);
        chk("uflow_halt", {15'd0, halted}, 16'd1);
        chk_issue("donest", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_stall", stall_cycles, 16'd4);

        // async reset mid-RUN with occupancy (2,1)
        rst = 1'b1;
        #2;
        rst = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        set_in(1'b1, 8'h02, 1'b1, 8'h04);
        step();
        set_in(1'b1, 8'h01, 1'b0, 8'h00);
        step();
        chk_cnt("pre6", 3'd2, 3'd1);
        set_in(1'b1, 8'h01, 1'b1, 8'h03);
        chk_issue("pre6", 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_issue("t6", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("t6", 3'd0, 3'd0);
        chk("t6_stall", stall_cycles, 16'd0);
        chk("t6_halt", {15'd0, halted}, 16'd0);
        #1;
        rst = 1'b0;
        step();
        step();
        chk_issue("t6idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("t6idle", 3'd0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
